count_bcd_display: RTL and testbench
====================================

COUNT_BCD_DISPLAY -- requirements
Module: count_bcd_display

Interface
REQ-001 Parameter WIDTH, default 16, sets the binary counter width in bits (2..32).
REQ-002 Parameter DIGITS, default 5, sets the number of BCD/7-seg digits; DIGITS*4 SHALL be >= the bits needed for 2^WIDTH-1 in decimal (checked at elaboration).
REQ-003 Parameter DIV, default 50000, sets the tick prescaler period in clock cycles; DIV SHALL be >= WIDTH+3.
REQ-004 Parameter SATURATE, default 0: 0 = wrap at limits, 1 = clamp at limits.
REQ-005 Parameter BLANK, default 1: 1 = leading-zero blanking on, 0 = off.
REQ-006 CLOCK_50  in  1  single system clock; all state on its rising edge.
REQ-007 RESET_N  in  1  asynchronous, active-low reset.
REQ-008 en  in  1  count enable, qualified by tick.
REQ-009 up  in  1  direction: 1 = increment, 0 = decrement.
REQ-010 clr  in  1  synchronous clear of count.
REQ-011 load  in  1  synchronous load of load_val into count.
REQ-012 load_val  in  WIDTH  load value.
REQ-013 count  out  WIDTH  registered binary count.
REQ-014 tick  out  1  one-cycle prescaler pulse.
REQ-015 limit  out  1  one-cycle pulse on overflow/underflow attempt.
REQ-016 bcd  out  4*DIGITS  registered BCD digits; digit 0 in bits [3:0].
REQ-017 bcd_valid  out  1  one-cycle pulse when bcd is updated.
REQ-018 seg  out  7*DIGITS  active-low segments {g,f,e,d,c,b,a} per digit; digit 0 in bits [6:0].

Function
REQ-019 Prescaler counts 0..DIV-1 freely; tick SHALL be 1 exactly in the cycle the prescaler equals DIV-1, independent of en/clr/load.
REQ-020 Count update priority per cycle: clr (count=0) > load (count=load_val) > step (en && tick) > hold.
REQ-021 Step up: count+1; at 2^WIDTH-1, next value is 0 (SATURATE=0) or unchanged (SATURATE=1), and limit pulses in either mode.
REQ-022 Step down: count-1; at 0, next value is 2^WIDTH-1 (SATURATE=0) or 0 (SATURATE=1), and limit pulses in either mode.
REQ-023 limit SHALL be registered, asserted the cycle after the limiting step, never from clr or load.
REQ-024 Converter FSM states: IDLE, SHIFT, DONE.
REQ-025 IDLE: when count != last_conv, snapshot count into shift register and last_conv, clear BCD scratch, go SHIFT; else stay.
REQ-026 SHIFT: iterative double-dabble, exactly WIDTH cycles; each cycle add 3 to every scratch digit >= 5, then shift {scratch, snapshot} left 1; after WIDTH cycles go DONE.
REQ-027 DONE: bcd <= scratch, bcd_valid=1 for this single cycle, return to IDLE.
REQ-028 Latency: bcd reflects a new count WIDTH+2 cycles after count changes, when the converter is idle.
REQ-029 Count changes during SHIFT/DONE SHALL NOT disturb the conversion in progress; the newest count is picked up on return to IDLE (intermediate values may be skipped).
REQ-030 seg digit d decodes bcd digit d: 0..9 to standard active-low patterns (0 = 1000000, 1 = 1111001, 8 = 0000000); codes 10..15 SHALL display all-off (1111111).
REQ-031 BLANK=1: digits above the most significant non-zero digit display 1111111; digit 0 always displayed.
REQ-032 seg SHALL be combinational from the registered bcd only (no glitch from scratch).

Reset
REQ-033 RESET_N low SHALL immediately force: count=0, prescaler=0, tick=0, limit=0, bcd=0, bcd_valid=0, last_conv=0, scratch=0, FSM=IDLE.
REQ-034 After reset, seg digit 0 = 1000000; higher digits = 1111111 (BLANK=1) or 1000000 (BLANK=0); no conversion starts until count changes.
REQ-035 Reset asserted mid-conversion SHALL abort it with no bcd_valid pulse; deassertion SHALL be synchronised so the first active edge is clean.

Verification
REQ-036 DIV=20, en=1, up=1 from reset: tick every 20 cycles; after 3 ticks count=3, bcd=0x00003, bcd_valid pulses 18 cycles after each step.
REQ-037 load_val=65535, load=1, then one step with up=1: SATURATE=0 gives count=0 and a limit pulse; SATURATE=1 gives count=65535 and a limit pulse.
REQ-038 count=0, up=0, one step: SATURATE=0 gives 65535, bcd=0x65535; SATURATE=1 stays 0; limit pulses in both.
REQ-039 clr and load both asserted with en&&tick: count=0 next cycle, no limit pulse.
REQ-040 load 12345, then load 99 three cycles later (mid-SHIFT): bcd_valid shows 0x12345 first, then 0x00099; seg digits 2-4 = 1111111 with BLANK=1.
REQ-041 RESET_N pulsed low at SHIFT cycle 8: no bcd_valid, all outputs at reset values, next load converts correctly.

Source files
------------

// File: rtl/count_bcd_display.sv
`default_nettype none
// ============================================================================
// count_bcd_display : prescaled up/down counter with double-dabble BCD
//                     converter and leading-zero-blanked 7-segment outputs
// Revision 1.0
// ============================================================================
module count_bcd_display #(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 5,
    parameter int DIV      = 50000,
    parameter bit SATURATE = 1'b0,
    parameter bit BLANK    = 1'b1
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    output logic [WIDTH-1:0]      count,
    output logic                  tick,
    output logic                  limit,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BW = 4 * DIGITS;

    function automatic int dec_digits(input int w);
        longint unsigned v;
        int              n;
        v = (longint'(1) << w) - 1;
        n = 0;
        do begin
            v = v / 10;
            n++;
        end while (v != 0);
        return n;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("WIDTH must be in 2..32");
    end
    if (DIV < WIDTH + 3) begin : g_bad_div
        $error("DIV must be >= WIDTH+3");
    end
    if (DIGITS < dec_digits(WIDTH)) begin : g_bad_digits
        $error("DIGITS too small for 2^WIDTH-1");
    end

    // Reset asserts asynchronously, releases on a clock edge.
    logic rst_meta_q, rst_sync_q, rst_n;
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end
    assign rst_n = rst_sync_q;

    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             limit_q, limit_d;

    assign tick = (presc_q == PW'(DIV - 1));

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        count_d = count_q;
        limit_d = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en && tick) begin
            if (up) begin
                if (count_q == '1) begin
                    limit_d = 1'b1;
                    count_d = SATURATE ? count_q : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    limit_d = 1'b1;
                    count_d = SATURATE ? count_q : '1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [BW-1:0]    scratch_q, scratch_d;
    logic [BW-1:0]    adj;
    logic [CW-1:0]    bit_q, bit_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             valid_q, valid_d;

    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        last_d    = last_q;
        scratch_d = scratch_q;
        bit_d     = bit_q;
        bcd_d     = bcd_q;
        valid_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != last_q) begin
                    snap_d    = count_q;
                    last_d    = count_q;
                    scratch_d = '0;
                    bit_d     = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                scratch_d = {adj[BW-2:0], snap_q[WIDTH-1]};
                snap_d    = snap_q << 1;
                bit_d     = bit_q + CW'(1);
                if (bit_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d   = scratch_q;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            count_q   <= '0;
            limit_q   <= 1'b0;
            state_q   <= S_IDLE;
            snap_q    <= '0;
            last_q    <= '0;
            scratch_q <= '0;
            bit_q     <= '0;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            state_q   <= state_d;
            snap_q    <= snap_d;
            last_q    <= last_d;
            scratch_q <= scratch_d;
            bit_q     <= bit_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
        end
    end

    assign count     = count_q;
    assign limit     = limit_q;
    assign bcd       = bcd_q;
    assign bcd_valid = valid_q;

    // A digit is shown if it or any higher digit is non-zero; digit 0 always.
    logic [DIGITS-1:0] show;
    logic              seen;
    always_comb begin
        seen = 1'b0;
        show = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen    = seen | (bcd_q[4*i +: 4] != 4'd0);
            show[i] = seen || (i == 0) || !BLANK;
        end
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        assign seg[7*d +: 7] = show[d] ? decode(bcd_q[4*d +: 4]) : 7'b1111111;
    end

endmodule
`default_nettype wire

// File: tb/tb_count_bcd_display.sv
`default_nettype none
// ============================================================================
// tb_count_bcd_display : scoreboard bench, wrap (blanked) and clamp (unblanked)
// Revision 1.0
// ============================================================================
module tb_count_bcd_display;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        en, up, clr, load;
    logic [15:0] load_val;
    logic [15:0] count0, count1;
    logic        tick0, tick1, limit0, limit1, bv0, bv1;
    logic [19:0] bcd0, bcd1;
    logic [34:0] seg0, seg1;

    int checks = 0;
    int errors = 0;
    logic [19:0] q0[$];
    logic [19:0] q1[$];

    always #5 clk = ~clk;

    count_bcd_display #(.WIDTH(16), .DIGITS(5), .DIV(20), .SATURATE(1'b0), .BLANK(1'b1)) u_dut0 (
        .CLOCK_50(clk), .RESET_N(rst_n_i), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .count(count0), .tick(tick0), .limit(limit0),
        .bcd(bcd0), .bcd_valid(bv0), .seg(seg0));

    count_bcd_display #(.WIDTH(16), .DIGITS(5), .DIV(20), .SATURATE(1'b1), .BLANK(1'b0)) u_dut1 (
        .CLOCK_50(clk), .RESET_N(rst_n_i), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .count(count1), .tick(tick1), .limit(limit1),
        .bcd(bcd1), .bcd_valid(bv1), .seg(seg1));

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [34:0] seg_model(input logic [19:0] b, input bit blank);
        logic [34:0] s;
        bit          nz;
        nz = 0;
        for (int i = 4; i >= 0; i--) begin
            if (b[4*i +: 4] != 0) nz = 1;
            s[7*i +: 7] = (nz || i == 0 || !blank) ? seg_digit(b[4*i +: 4]) : 7'h7F;
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic monitor();
        logic [19:0] e;
        forever begin
            @(negedge clk);
            if (bv0) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL sb0_unexpected got bcd=%h", bcd0);
                end else begin
                    e = q0.pop_front();
                    if (bcd0 !== e || seg0 !== seg_model(e, 1'b1)) begin
                        errors++;
                        $display("FAIL sb0_bcd got bcd=%h seg=%h want bcd=%h seg=%h",
                                 bcd0, seg0, e, seg_model(e, 1'b1));
                    end
                end
            end
            if (bv1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL sb1_unexpected got bcd=%h", bcd1);
                end else begin
                    e = q1.pop_front();
                    if (bcd1 !== e || seg1 !== seg_model(e, 1'b0)) begin
                        errors++;
                        $display("FAIL sb1_bcd got bcd=%h seg=%h want bcd=%h seg=%h",
                                 bcd1, seg1, e, seg_model(e, 1'b0));
                    end
                end
            end
        end
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tick0) return;
        end
        chk("tick_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [19:0] step_bcd [3];
    int          lat;

    initial begin
        step_bcd = '{20'h00001, 20'h00002, 20'h00003};
        rst_n_i = 1'b0; en = 0; up = 1; clr = 0; load = 0; load_val = '0;
        fork monitor(); join_none

        // Reset values
        idle(3);
        chk("rst_count", count0, 0);
        chk("rst_tick", tick0, 0);
        chk("rst_bcd", bcd0, 0);
        chk("rst_seg_blank", seg0, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        chk("rst_seg_noblank", seg1, {5{7'h40}});
        rst_n_i = 1'b1;

        // Three up-steps, with step-to-bcd_valid latency
        en = 1; up = 1;
        for (int k = 0; k < 3; k++) begin
            wait_tick();
            q0.push_back(step_bcd[k]);
            q1.push_back(step_bcd[k]);
            @(posedge clk);
            lat = -1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (i == 0) chk("step_count", count0, k + 1);
                if (bv0) begin
                    lat = i;
                    break;
                end
            end
            chk("step_latency", lat, 18);
        end
        en = 0;
        chk("bcd_after_3", bcd0, 20'h00003);

        // Overflow at 65535
        load = 1; load_val = 16'd65535;
        q0.push_back(20'h65535); q1.push_back(20'h65535);
        idle(1); load = 0;
        idle(25);
        wait_tick();
        en = 1; up = 1;
        q0.push_back(20'h00000);
        idle(1); en = 0;
        chk("ovf_count_wrap", count0, 0);
        chk("ovf_count_sat", count1, 16'd65535);
        chk("ovf_limit_wrap", limit0, 1);
        chk("ovf_limit_sat", limit1, 1);
        idle(1);
        chk("ovf_limit_pulse", limit0, 0);
        idle(25);

        // Underflow at 0
        clr = 1;
        q1.push_back(20'h00000);
        idle(1); clr = 0;
        idle(25);
        wait_tick();
        en = 1; up = 0;
        q0.push_back(20'h65535);
        idle(1); en = 0;
        chk("unf_count_wrap", count0, 16'd65535);
        chk("unf_count_sat", count1, 0);
        chk("unf_limit_wrap", limit0, 1);
        chk("unf_limit_sat", limit1, 1);
        idle(25);

        // clr + load + step together: clr wins, no limit
        wait_tick();
        clr = 1; load = 1; load_val = 16'd1234; en = 1; up = 0;
        q0.push_back(20'h00000);
        idle(1); clr = 0; load = 0; en = 0;
        chk("prio_count0", count0, 0);
        chk("prio_count1", count1, 0);
        chk("prio_limit0", limit0, 0);
        chk("prio_limit1", limit1, 0);
        idle(25);

        // Reload mid-conversion
        load = 1; load_val = 16'd12345;
        q0.push_back(20'h12345); q1.push_back(20'h12345);
        idle(1); load = 0;
        idle(2);
        load = 1; load_val = 16'd99;
        q0.push_back(20'h00099); q1.push_back(20'h00099);
        idle(1); load = 0;
        idle(45);
        chk("mid_bcd", bcd0, 20'h00099);
        chk("mid_seg_hi_blank", seg0[34:14], 21'h1FFFFF);
        chk("mid_seg_hi_noblank", seg1[20:14], 7'h40);

        // Reset mid-SHIFT aborts the conversion
        load = 1; load_val = 16'd500;
        idle(1); load = 0;
        idle(8);
        rst_n_i = 1'b0;
        #1;
        chk("arst_count", count0, 0);
        chk("arst_bcd", bcd0, 0);
        chk("arst_valid", bv0, 0);
        chk("arst_limit", limit0, 0);
        chk("arst_tick", tick0, 0);
        idle(3);
        rst_n_i = 1'b1;
        idle(25);
        chk("post_rst_bcd", bcd0, 0);
        chk("post_rst_seg", seg0, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        load = 1; load_val = 16'd4321;
        q0.push_back(20'h04321); q1.push_back(20'h04321);
        idle(1); load = 0;
        idle(25);
        chk("post_rst_conv", bcd0, 20'h04321);

        chk("sb0_drained", q0.size(), 0);
        chk("sb1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
